stream_demux: RTL

Registered, handshaked 1-to-N demultiplexer for streaming datapaths. It accepts one beat per cycle on a valid/ready input, then steers the beat to one selected output channel, or copies it to all channels in broadcast mode. Each channel has its own one-entry output register, so a stalled channel does not block beats bound for other channels. It sits between a single producer and N independent consumers.

---
 rtl/demux_pkg.sv | 16 +
 rtl/demux_out_reg.sv | 35 +++
 rtl/stream_demux.sv | 95 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package demux_pkg;

   // Steering mode carried alongside each input beat.
   typedef enum logic {
      MODE_UNICAST   = 1'b0,
      MODE_BROADCAST = 1'b1
   } demux_mode_t;

   // True when sel names an existing channel. Only matters when the
   // channel count is not a power of two.
   function automatic logic is_valid_sel(input logic [31:0] sel, input int unsigned outputs);
      return (sel < outputs);
   endfunction

endpackage

// File: rtl/demux_out_reg.sv
// One-entry valid/ready output register for a single demux channel.
// The parent only asserts load when this entry is empty or draining, so a
// load always wins over a drain and keeps the channel at full throughput.
module demux_out_reg #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic                  valid_reg;
   logic [DATA_WIDTH-1:0] data_reg;

   // Load replaces the held beat; otherwise a completed handshake empties the entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= load_data;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   assign out_valid = valid_reg;
   assign out_data  = data_reg;

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with unicast and broadcast modes.
// Each channel owns a one-entry register, so a stalled consumer only blocks
// beats that target it. Unicast beats with a nonexistent select are
// swallowed and flagged on sel_err one cycle later.
module stream_demux
   import demux_pkg::*;
#(
   parameter int OUTPUTS    = 8,
   parameter int SEL_BITS   = $clog2(OUTPUTS),
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [SEL_BITS-1:0]   in_sel,
   input  logic                  in_mode,
   output logic [OUTPUTS-1:0]    out_valid,
   input  logic [OUTPUTS-1:0]    out_ready,
   output logic [DATA_WIDTH-1:0] out_data [OUTPUTS],
   output logic                  sel_err
);

   demux_mode_t          mode;
   logic [OUTPUTS-1:0]   free;
   logic [OUTPUTS-1:0]   load;
   logic                 sel_ok;
   logic                 uni_free;
   logic                 accept;
   logic                 sel_err_reg;
   logic                 sel_err_next;

   assign mode   = demux_mode_t'(in_mode);
   assign sel_ok = is_valid_sel(32'(in_sel), OUTPUTS);

   // Per-channel storage and steering; a channel is free when empty or draining.
   generate
      for (genvar gi = 0; gi < OUTPUTS; gi++) begin : gen_ch
         assign free[gi] = !out_valid[gi] || out_ready[gi];
         assign load[gi] = accept &&
                           ((mode == MODE_BROADCAST) ||
                            (sel_ok && (in_sel == SEL_BITS'(gi))));

         demux_out_reg #(
            .DATA_WIDTH (DATA_WIDTH)
         ) u_out_reg (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[gi]),
            .load_data (in_data),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi])
         );
      end
   endgenerate

   // Free status of the unicast target, found by compare so an out-of-range
   // select never indexes past the channel vector.
   always_comb begin
      uni_free = 1'b0;
      for (int i = 0; i < OUTPUTS; i++) begin
         if (in_sel == SEL_BITS'(i)) begin
            uni_free = free[i];
         end
      end
   end

   // Input handshake: broadcast needs every channel, unicast its target,
   // and an out-of-range unicast is always taken so it can be discarded.
   always_comb begin
      if (mode == MODE_BROADCAST) begin
         in_ready = &free;
      end else if (sel_ok) begin
         in_ready = uni_free;
      end else begin
         in_ready = 1'b1;
      end
      accept       = in_valid && in_ready && rst_n;
      sel_err_next = accept && (mode == MODE_UNICAST) && !sel_ok;
   end

   // Registered drop indicator, one pulse per discarded beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_err_reg <= 1'b0;
      end else begin
         sel_err_reg <= sel_err_next;
      end
   end

   assign sel_err = sel_err_reg;

endmodule
